// File: rtl/preg_freelist_ctrl_pkg.sv
// Shared free-list constants and types for the rename stage.
// Default sizing: 64 physical registers, 32 permanently mapped at reset.
package preg_freelist_ctrl_pkg;

    localparam int PREG_NUM = 64;
    localparam int AREG_NUM = 32;
    localparam int FL_WIDTH = 4;
    localparam int FL_DEPTH = PREG_NUM - AREG_NUM;
    localparam int PREG_W   = $clog2(PREG_NUM);
    localparam int FL_PTR_W = $clog2(FL_DEPTH) + 1;

    typedef logic [PREG_W-1:0]   preg_idx_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/preg_freelist_ctrl_lane_compact.sv
// Valid-mask compactor: each lane gets the number of set lanes below it
// (its write offset), plus the total popcount of the mask.
module fl_lane_compact
    import preg_freelist_ctrl_pkg::*;
#(
    parameter int  LANES = FL_WIDTH,
    localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int CNT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]            valid,
    output logic [LANES-1:0][OFF_W-1:0] offset,
    output logic [CNT_W-1:0]            count
);

    logic [CNT_W-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int k = 0; k < LANES; k++) begin
            offset[k] = acc[OFF_W-1:0];
            acc       = acc + CNT_W'(valid[k]);
        end
        count = acc;
    end

endmodule

// File: rtl/preg_freelist_ctrl.sv
// Circular physical-register free list: rename allocates from a speculative
// head, commit advances an architectural head, flush snaps speculative back.
module preg_freelist_ctrl #(
    parameter int  PREG_NUM = preg_freelist_ctrl_pkg::PREG_NUM,
    parameter int  AREG_NUM = preg_freelist_ctrl_pkg::AREG_NUM,
    parameter int  WIDTH    = preg_freelist_ctrl_pkg::FL_WIDTH,
    localparam int DEPTH    = PREG_NUM - AREG_NUM,
    localparam int PW       = $clog2(PREG_NUM),
    localparam int PTR_W    = $clog2(DEPTH) + 1,
    localparam int IDX_W    = PTR_W - 1,
    localparam int OFF_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [2:0]        alloc_req_cnt,
    output logic              alloc_ready,
    output logic [PW-1:0]     alloc_preg [WIDTH],
    input  logic [WIDTH-1:0]  free_valid,
    input  logic [PW-1:0]     free_preg [WIDTH],
    input  logic [2:0]        commit_alloc_cnt,
    output logic [PTR_W-1:0]  free_count,
    output logic [PTR_W-1:0]  arch_free_count
);

    // Handshake: a bundle is taken when alloc_valid && alloc_ready && !flush;
    // alloc_ready depends only on registered free_count, never on alloc_valid.
    logic [PW-1:0]    fifo [DEPTH];
    logic [PTR_W-1:0] spec_head, arch_head, tail;

    logic [WIDTH-1:0][OFF_W-1:0] wr_off;
    logic [CNT_W-1:0]            rel_cnt;

    logic             fire;
    logic [PTR_W-1:0] rel_amt, alloc_amt, commit_amt;
    logic [PTR_W-1:0] arch_head_next, arch_free_next, free_next, spec_next;

    fl_lane_compact #(.LANES(WIDTH)) u_compact (
        .valid  (free_valid),
        .offset (wr_off),
        .count  (rel_cnt)
    );

    assign alloc_ready = free_count >= PTR_W'(alloc_req_cnt);
    assign fire        = alloc_valid && alloc_ready && !flush;

    for (genvar k = 0; k < WIDTH; k++) begin : g_rd
        assign alloc_preg[k] = fifo[spec_head[IDX_W-1:0] + IDX_W'(k)];
    end

    // Commit is folded in before a flush restores the speculative head.
    always_comb begin
        rel_amt        = PTR_W'(rel_cnt);
        alloc_amt      = fire ? PTR_W'(alloc_req_cnt) : '0;
        commit_amt     = PTR_W'(commit_alloc_cnt);
        arch_head_next = arch_head + commit_amt;
        arch_free_next = arch_free_count + rel_amt - commit_amt;
        free_next      = flush ? arch_free_next : free_count + rel_amt - alloc_amt;
        spec_next      = flush ? arch_head_next : spec_head + alloc_amt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_head       <= '0;
            arch_head       <= '0;
            tail            <= PTR_W'(DEPTH);
            free_count      <= PTR_W'(DEPTH);
            arch_free_count <= PTR_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= PW'(AREG_NUM + i);
            end
        end else begin
            spec_head       <= spec_next;
            arch_head       <= arch_head_next;
            tail            <= tail + rel_amt;
            free_count      <= free_next;
            arch_free_count <= arch_free_next;
            for (int k = 0; k < WIDTH; k++) begin
                if (free_valid[k]) begin
                    fifo[tail[IDX_W-1:0] + IDX_W'(wr_off[k])] <= free_preg[k];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Commit may only retire allocations that rename has already handed out.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (free_next <= PTR_W'(DEPTH))
                else $error("free_count overflow");
            assert (arch_free_next <= PTR_W'(DEPTH))
                else $error("arch_free_count overflow");
            assert (arch_free_next >= free_next)
                else $error("arch_free_count below free_count");
            assert (commit_amt <= arch_free_count - free_count)
                else $error("commit exceeds outstanding allocations");
        end
    end
`endif

endmodule

// File: tb/tb_preg_freelist_ctrl.sv
// Directed bench for preg_freelist_ctrl: vector tables for allocate/release/
// flush, then a long wrap-around sequence checked against a FIFO scoreboard.
module tb_preg_freelist_ctrl;

    localparam int PW = 6;
    localparam int W  = 4;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          alloc_valid = 1'b0;
    logic [2:0]    alloc_req_cnt = '0;
    logic          alloc_ready;
    logic [PW-1:0] alloc_preg [W];
    logic [W-1:0]  free_valid = '0;
    logic [PW-1:0] free_preg [W];
    logic [2:0]    commit_alloc_cnt = '0;
    logic [CW-1:0] free_count;
    logic [CW-1:0] arch_free_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    preg_freelist_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .alloc_valid      (alloc_valid),
        .alloc_req_cnt    (alloc_req_cnt),
        .alloc_ready      (alloc_ready),
        .alloc_preg       (alloc_preg),
        .free_valid       (free_valid),
        .free_preg        (free_preg),
        .commit_alloc_cnt (commit_alloc_cnt),
        .free_count       (free_count),
        .arch_free_count  (arch_free_count)
    );

    typedef struct packed {
        logic           fl;
        logic           av;
        logic [2:0]     req;
        logic [3:0]     fv;
        logic [3:0][5:0] fp;
        logic [2:0]     cm;
        logic           rdy;
        logic [3:0][5:0] ep;
        logic [5:0]     fc;
        logic [5:0]     afc;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic vec_t mk(input int fl, av, req, fv, p0, p1, p2, p3, cm,
                                input int rdy, e0, e1, e2, e3, fc, afc);
        vec_t v;
        v.fl  = 1'(fl);
        v.av  = 1'(av);
        v.req = 3'(req);
        v.fv  = 4'(fv);
        v.fp  = {6'(p3), 6'(p2), 6'(p1), 6'(p0)};
        v.cm  = 3'(cm);
        v.rdy = 1'(rdy);
        v.ep  = {6'(e3), 6'(e2), 6'(e1), 6'(e0)};
        v.fc  = 6'(fc);
        v.afc = 6'(afc);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic av, input logic [2:0] req,
                         input logic [3:0] fv, input logic [3:0][5:0] fp,
                         input logic [2:0] cm);
        flush            = fl;
        alloc_valid      = av;
        alloc_req_cnt    = req;
        free_valid       = fv;
        commit_alloc_cnt = cm;
        for (int k = 0; k < W; k++) free_preg[k] = fp[k];
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 4'd0, '0, 3'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, "_rst_ready"}, int'(alloc_ready), 1);
        check({tag, "_rst_fc"}, int'(free_count), 32);
        check({tag, "_rst_afc"}, int'(arch_free_count), 32);
        for (int k = 0; k < W; k++)
            check($sformatf("%s_rst_preg%0d", tag, k), int'(alloc_preg[k]), 32 + k);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v.fl, v.av, v.req, v.fv, v.fp, v.cm);
        #1;
        check({tag, "_ready"}, int'(alloc_ready), int'(v.rdy));
        for (int k = 0; k < W; k++)
            check($sformatf("%s_preg%0d", tag, k), int'(alloc_preg[k]), int'(v.ep[k]));
        @(posedge clk);
        #1;
        check({tag, "_fc"}, int'(free_count), int'(v.fc));
        check({tag, "_afc"}, int'(arch_free_count), int'(v.afc));
    endtask

    logic [5:0]  exp_q[$];
    logic [5:0]  prev [4];
    logic [5:0]  cur [4];
    logic [63:0] outstanding;
    logic [3:0][5:0] fp_w;

    initial begin
        for (int k = 0; k < W; k++) free_preg[k] = '0;

        // Allocation, drain to empty, same-cycle release blocking, sparse release.
        for (int i = 0; i < 8; i++)
            tbl_a.push_back(mk(0,1,4,0, 0,0,0,0, 0, 1, 32+4*i,33+4*i,34+4*i,35+4*i, 28-4*i, 32));
        tbl_a.push_back(mk(0,1,1,4'b0000, 0,0,0,0, 4, 0, 32,33,34,35, 0, 28));
        tbl_a.push_back(mk(0,1,1,4'b0001, 5,0,0,0, 0, 0, 32,33,34,35, 1, 29));
        tbl_a.push_back(mk(0,1,1,4'b0000, 0,0,0,0, 0, 1, 5,33,34,35, 0, 29));
        tbl_a.push_back(mk(0,1,0,4'b0000, 0,0,0,0, 0, 1, 33,34,35,36, 0, 29));
        tbl_a.push_back(mk(0,0,0,4'b0011, 6,7,0,0, 3, 1, 33,34,35,36, 2, 28));
        tbl_a.push_back(mk(0,0,0,4'b0100, 0,0,8,0, 0, 1, 6,7,35,36, 3, 29));
        tbl_a.push_back(mk(0,1,4,4'b1001, 9,0,0,10, 2, 0, 6,7,8,36, 5, 29));
        tbl_a.push_back(mk(0,1,4,4'b0000, 0,0,0,0, 0, 1, 6,7,8,9, 1, 29));
        tbl_a.push_back(mk(0,0,0,4'b1010, 0,40,0,41, 0, 1, 10,38,39,40, 3, 31));
        tbl_a.push_back(mk(0,1,3,4'b0000, 0,0,0,0, 0, 1, 10,40,41,40, 0, 31));

        // Commit then flush recovery, flush with allocation, flush with release.
        for (int i = 0; i < 3; i++)
            tbl_b.push_back(mk(0,1,4,0, 0,0,0,0, 0, 1, 32+4*i,33+4*i,34+4*i,35+4*i, 28-4*i, 32));
        tbl_b.push_back(mk(0,0,0,4'b0000, 0,0,0,0, 4, 1, 44,45,46,47, 20, 28));
        tbl_b.push_back(mk(1,0,0,4'b0000, 0,0,0,0, 2, 1, 44,45,46,47, 26, 26));
        tbl_b.push_back(mk(0,0,0,4'b0000, 0,0,0,0, 0, 1, 38,39,40,41, 26, 26));
        tbl_b.push_back(mk(0,1,4,4'b0000, 0,0,0,0, 0, 1, 38,39,40,41, 22, 26));
        tbl_b.push_back(mk(1,1,2,4'b0000, 0,0,0,0, 1, 1, 42,43,44,45, 25, 25));
        tbl_b.push_back(mk(0,0,0,4'b0000, 0,0,0,0, 0, 1, 39,40,41,42, 25, 25));
        tbl_b.push_back(mk(1,0,0,4'b0100, 0,0,12,0, 0, 1, 39,40,41,42, 26, 26));
        tbl_b.push_back(mk(0,0,0,4'b0000, 0,0,0,0, 0, 1, 39,40,41,42, 26, 26));

        do_reset("a");
        foreach (tbl_a[i]) run_vec(tbl_a[i], $sformatf("a%0d", i));

        do_reset("b");
        foreach (tbl_b[i]) run_vec(tbl_b[i], $sformatf("b%0d", i));

        // Steady-state wrap: allocate 4, release last cycle's 4, commit 4.
        do_reset("w");
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
        outstanding = '0;
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd4, 4'd0, '0, 3'd0);
        #1;
        for (int k = 0; k < W; k++) begin
            cur[k] = exp_q.pop_front();
            check($sformatf("w_pre_preg%0d", k), int'(alloc_preg[k]), int'(cur[k]));
            outstanding[cur[k]] = 1'b1;
            prev[k] = cur[k];
        end
        @(posedge clk);
        #1;
        check("w_pre_fc", int'(free_count), 28);

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            fp_w = {prev[3], prev[2], prev[1], prev[0]};
            drive(1'b0, 1'b1, 3'd4, 4'hF, fp_w, 3'd4);
            #1;
            check($sformatf("w%0d_ready", c), int'(alloc_ready), 1);
            for (int k = 0; k < W; k++) outstanding[prev[k]] = 1'b0;
            for (int k = 0; k < W; k++) begin
                cur[k] = exp_q.pop_front();
                check($sformatf("w%0d_preg%0d", c, k), int'(alloc_preg[k]), int'(cur[k]));
                check($sformatf("w%0d_dup%0d", c, k), int'(outstanding[alloc_preg[k]]), 0);
                outstanding[cur[k]] = 1'b1;
            end
            for (int k = 0; k < W; k++) exp_q.push_back(prev[k]);
            for (int k = 0; k < W; k++) prev[k] = cur[k];
            @(posedge clk);
            #1;
            check($sformatf("w%0d_fc", c), int'(free_count), 28);
            check($sformatf("w%0d_afc", c), int'(arch_free_count), 32);
        end

        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
